// File: rtl/gnss_pkg.sv
// Shared types and helpers for the early/prompt/late code correlator:
// 2-bit sample decode, the grouped sum record and the saturating add.
package gnss_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef logic signed [2:0] sample_t;

  typedef struct packed {
    logic signed [ACC_W_DEF-1:0] ie;
    logic signed [ACC_W_DEF-1:0] qe;
    logic signed [ACC_W_DEF-1:0] ip;
    logic signed [ACC_W_DEF-1:0] qp;
    logic signed [ACC_W_DEF-1:0] il;
    logic signed [ACC_W_DEF-1:0] ql;
  } corr_t;

  // d1 selects magnitude 3 vs 1, d0 flips the sign.
  function automatic sample_t decode_sample(input logic d0, input logic d1);
    sample_t mag;
    mag = d1 ? 3'sd3 : 3'sd1;
    return d0 ? sample_t'(-mag) : mag;
  endfunction

  // Operands must already fit in w bits; the sum is clamped to the w-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/gnss_corr_acc.sv
// One saturating correlation accumulator; an epoch restarts it with the
// coincident sample's product so that sample opens the new period.
module gnss_corr_acc
  import gnss_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid_i,
  input  logic                    epoch_i,
  input  sample_t                 prod_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (epoch_i) begin
      acc_d = sample_valid_i ? ACC_W'(prod_i) : '0;
    end else if (sample_valid_i) begin
      acc_d = ACC_W'(sat_add(64'(acc_q), 64'(prod_i), ACC_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/gnss_code_correlator.sv
// E/P/L code-wipeoff correlator: replica delay line, six accumulators and a
// valid/ready dump register that a new epoch always overwrites.
module gnss_code_correlator
  import gnss_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic                    i_d0,
  input  logic                    i_d1,
  input  logic                    q_d0,
  input  logic                    q_d1,
  input  logic                    chip,
  input  logic                    code_tick,
  input  logic                    epoch,
  output logic signed [ACC_W-1:0] out_ie,
  output logic signed [ACC_W-1:0] out_qe,
  output logic signed [ACC_W-1:0] out_ip,
  output logic signed [ACC_W-1:0] out_qp,
  output logic signed [ACC_W-1:0] out_il,
  output logic signed [ACC_W-1:0] out_ql,
  output logic [CNT_W-1:0]        out_epoch_cnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  // tap_q[0] = early, [1] = prompt, [2] = late
  logic [2:0]             tap_q;
  logic [2:0]             tap_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [5:0][ACC_W-1:0]  acc_w;
  logic [5:0][ACC_W-1:0]  sums_q;
  logic [5:0][ACC_W-1:0]  sums_d;
  logic [CNT_W-1:0]       out_cnt_q;
  logic [CNT_W-1:0]       out_cnt_d;
  logic                   out_valid_q;
  logic                   out_valid_d;
  logic                   overrun_q;
  logic                   overrun_d;

  sample_t i_s;
  sample_t q_s;

  assign i_s = decode_sample(i_d0, i_d1);
  assign q_s = decode_sample(q_d0, q_d1);

  // Channel order ie, qe, ip, qp, il, ql: even channels take I, tap = index/2.
  // Products use tap_q, i.e. the replica before any coincident code_tick shift.
  for (genvar gi = 0; gi < 6; gi++) begin : g_ch
    sample_t samp;
    sample_t prod;

    assign samp = ((gi % 2) == 0) ? i_s : q_s;
    assign prod = tap_q[gi / 2] ? samp : sample_t'(-samp);

    gnss_corr_acc #(
      .ACC_W(ACC_W)
    ) u_acc (
      .clk           (clk),
      .rst           (rst),
      .sample_valid_i(sample_valid),
      .epoch_i       (epoch),
      .prod_i        (prod),
      .acc_o         (acc_w[gi])
    );
  end

  always_comb begin
    tap_d       = tap_q;
    cnt_d       = cnt_q;
    sums_d      = sums_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (code_tick) begin
      tap_d = {tap_q[1:0], chip};
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A dump wins over a same-cycle transfer; unread data lost sets the sticky flag.
    if (epoch) begin
      sums_d      = acc_w;
      out_cnt_d   = cnt_q;
      cnt_d       = cnt_q + CNT_W'(1);
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q       <= '0;
      cnt_q       <= '0;
      sums_q      <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      cnt_q       <= cnt_d;
      sums_q      <= sums_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_ie        = sums_q[0];
  assign out_qe        = sums_q[1];
  assign out_ip        = sums_q[2];
  assign out_qp        = sums_q[3];
  assign out_il        = sums_q[4];
  assign out_ql        = sums_q[5];
  assign out_epoch_cnt = out_cnt_q;
  assign out_valid     = out_valid_q;
  assign overrun       = overrun_q;

endmodule
